// File: rtl/fsm_input_sequencer.sv
// Command sequencer for 3-bit FSM user-input ports.
// Accepts (code, hold) commands into a small FIFO and replays each code on a
// registered user_input bus for max(hold,1) cycles, separated by GAP_LEN
// cycles of IDLE_CODE. seq_done pulses once when the queue drains to idle.
module fsm_input_sequencer #(
    parameter int          DEPTH     = 4,
    parameter int          HOLD_W    = 4,
    parameter int          GAP_LEN   = 1,
    parameter logic [2:0]  IDLE_CODE = 3'b111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 in_code,
    input  logic [HOLD_W-1:0]          in_hold,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [2:0]                 user_input,
    output logic                       drive_active,
    output logic                       seq_done,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 + HOLD_W;
    // gap counter only needs to hold GAP_LEN-1
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_e;

    // FIFO storage: depth is small, so the head entry is read combinationally
    // to allow the pop and the output load to happen on the same edge.
    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    state_e            state_q, state_d;
    logic [2:0]        user_q, user_d;
    logic              drive_q, drive_d;
    logic              done_q, done_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic [2:0]        head_code;
    logic [HOLD_W-1:0] head_hold;
    logic [HOLD_W-1:0] head_hold_m1;

    assign in_ready     = (count_q < CW'(DEPTH));
    // a push coinciding with reset is ignored
    assign push         = in_valid && in_ready && !rst;
    assign head         = mem_q[rd_ptr_q];
    assign head_code    = head[EW-1:HOLD_W];
    assign head_hold    = head[HOLD_W-1:0];
    // hold of zero behaves like a hold of one
    assign head_hold_m1 = (head_hold == '0) ? '0 : head_hold - HOLD_W'(1);

    assign user_input   = user_q;
    assign drive_active = drive_q;
    assign seq_done     = done_q;
    assign fifo_count   = count_q;

    // FIFO entry write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_code, in_hold};
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // sequencer next-state and registered output values
    always_comb begin
        state_d = state_q;
        user_d  = user_q;
        drive_d = drive_q;
        done_d  = 1'b0;
        hold_d  = hold_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                user_d  = IDLE_CODE;
                drive_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    user_d  = head_code;
                    hold_d  = head_hold_m1;
                    drive_d = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (hold_q == '0) begin
                    user_d  = IDLE_CODE;
                    gap_d   = GAP_INIT;
                    drive_d = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (count_q != '0) begin
                    // next queued command follows the gap with no bubble
                    pop     = 1'b1;
                    user_d  = head_code;
                    hold_d  = head_hold_m1;
                    drive_d = 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                user_d  = IDLE_CODE;
                drive_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, output and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            user_q   <= IDLE_CODE;
            drive_q  <= 1'b0;
            done_q   <= 1'b0;
            hold_q   <= '0;
            gap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            user_q   <= user_d;
            drive_q  <= drive_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
